// File: rtl/jk_pkg.sv
// Shared types and the J/K flip-flop next-state rule for the command driver
// and anything that models the downstream flip-flop.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } drv_state_t;

    function automatic logic jk_q_next(input logic q, input jk_op_t op);
        logic q_n;
        case (op)
            JK_HOLD:  q_n = q;
            JK_RESET: q_n = 1'b0;
            JK_SET:   q_n = 1'b1;
            default:  q_n = ~q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_cmd_driver_if.sv
// Command channel into the J/K driver.
// A command transfers on a rising edge where cmd_valid && cmd_ready; the master
// holds cmd_op/cmd_count stable while cmd_valid is high and not yet accepted.
interface jk_cmd_driver_if #(
    parameter int CNT_W = 4
);
    import jk_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jk_op_t           cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous FIFO holding queued {op, count} commands. Pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/jk_cmd_driver.sv
// Replays queued J/K commands as registered {j,k} pairs for count+1 cycles each,
// and tracks the q that the downstream flip-flop should hold.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jk_cmd_driver_if.slave        cmd,
    output logic                  j,
    output logic                  k,
    output logic                  busy,
    output logic                  done,
    output logic                  q_model,
    output drv_state_t            fsm_state
);
    localparam int W = 2 + CNT_W;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [W-1:0]     head;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    drv_state_t       state_r, state_n;
    logic [1:0]       jk_r, jk_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             done_r, done_n;
    logic             busy_r, busy_n;
    logic             q_r;

    assign push          = cmd.cmd_valid && !full;
    assign cmd.cmd_ready = !full;
    assign head_op       = head[W-1:CNT_W];
    assign head_cnt      = head[CNT_W-1:0];

    jk_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cmd.cmd_op, cmd.cmd_count}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            jk_r    <= JK_HOLD;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            jk_r    <= jk_n;
            cnt_r   <= cnt_n;
            done_r  <= done_n;
            busy_r  <= busy_n;
            // The flip-flop samples the same j/k we are presenting right now.
            q_r     <= jk_q_next(q_r, jk_op_t'(jk_r));
        end
    end

    always_comb begin
        state_n = state_r;
        jk_n    = jk_r;
        cnt_n   = cnt_r;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state_r)
            IDLE: pop = !empty;
            RUN: begin
                if (cnt_r != '0) begin
                    cnt_n  = cnt_r - CNT_W'(1);
                    done_n = (cnt_r == CNT_W'(1));
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_n = IDLE;
                    jk_n    = JK_HOLD;
                end
            end
            default: state_n = IDLE;
        endcase
        // A pop from either state loads the next command with no bubble.
        if (pop) begin
            state_n = RUN;
            jk_n    = head_op;
            cnt_n   = head_cnt;
            done_n  = (head_cnt == '0);
        end
        busy_n = (state_n == RUN) || push || !empty;
    end

    always_comb begin
        j         = jk_r[1];
        k         = jk_r[0];
        done      = done_r;
        busy      = busy_r;
        q_model   = q_r;
        fsm_state = state_r;
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: directed scenarios with literal expectations plus
// random command traffic checked every cycle against an expanded-stream model.
module tb_jk_cmd_driver;
    import jk_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       j, k, busy, done, q_model;
    drv_state_t fsm_state;

    jk_cmd_driver_if #(.CNT_W(CNT_W)) cmd_if ();

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .q_model   (q_model),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model: every accepted command expands into count+1 entries {first, done, op};
    // one entry is presented per clock. Entries still marked first are commands
    // that have not started, i.e. what the FIFO holds.
    logic [3:0] exp_q[$];
    logic [1:0] m_jk;
    logic       m_done, m_busy, m_q, m_ready, last_acc;
    logic       m_acc, m_popped;
    logic [3:0] m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][3]) n++;
        return n;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_jk = 2'b00; m_done = 1'b0; m_busy = 1'b0; m_q = 1'b0;
        m_ready = 1'b1; last_acc = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            m_acc = cmd_if.cmd_valid && m_ready;
            m_q   = jk_q_next(m_q, jk_op_t'(m_jk));
            m_popped = 1'b0;
            m_jk = 2'b00;
            m_done = 1'b0;
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                m_jk = m_e[1:0];
                m_done = m_e[2];
                m_popped = 1'b1;
            end
            if (m_acc) begin
                for (int i = 0; i <= int'(cmd_if.cmd_count); i++)
                    exp_q.push_back({(i == 0), (i == int'(cmd_if.cmd_count)), cmd_if.cmd_op});
            end
            last_acc = m_acc;
            m_busy   = m_popped || (exp_q.size() != 0);
            m_ready  = (occupancy() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_j", j, m_jk[1]);
            check("model_k", k, m_jk[0]);
            check("model_done", done, m_done);
            check("model_busy", busy, m_busy);
            check("model_q", q_model, m_q);
            check("model_ready", cmd_if.cmd_ready, m_ready);
        end
    end

    // Call right after a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [1:0] op, input int cnt);
        int guard = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = jk_op_t'(op);
        cmd_if.cmd_count = CNT_W'(cnt);
        do begin
            @(negedge clk);
            guard++;
        end while (!last_acc && guard < 100);
        if (!last_acc) check("send_timeout", 0, 1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int guard = 0;
        while ((m_busy || exp_q.size() != 0) && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (m_busy) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    logic [1:0] tog_jk [5] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic       tog_q  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        model_reset();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = JK_HOLD;
        cmd_if.cmd_count = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state held with no commands.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_jk", {j, k}, 2'b00);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_q", q_model, 1'b0);
            check("rst_ready", cmd_if.cmd_ready, 1'b1);
        end

        // Single SET, count 0.
        send(JK_SET, 0);
        check("set0_lat_jk", {j, k}, 2'b00);
        check("set0_lat_busy", busy, 1'b1);
        @(negedge clk);
        check("set0_jk", {j, k}, 2'b10);
        check("set0_done", done, 1'b1);
        check("set0_q_before", q_model, 1'b0);
        @(negedge clk);
        check("set0_after_jk", {j, k}, 2'b00);
        check("set0_after_done", done, 1'b0);
        check("set0_q", q_model, 1'b1);
        check("set0_busy_end", busy, 1'b0);

        send(JK_RESET, 0);
        wait_idle(50);
        check("q_cleared", q_model, 1'b0);

        // TOGGLE count 3 from q=0.
        send(JK_TOGGLE, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("tog_jk", {j, k}, tog_jk[c]);
            check("tog_done", done, (c == 3));
            check("tog_q", q_model, tog_q[c]);
        end

        // Back-to-back SET count 1 then RESET count 0.
        send(JK_SET, 1);
        send(JK_RESET, 0);
        check("b2b_jk1", {j, k}, 2'b10);
        check("b2b_done1", done, 1'b0);
        @(negedge clk);
        check("b2b_jk2", {j, k}, 2'b10);
        check("b2b_done2", done, 1'b1);
        @(negedge clk);
        check("b2b_jk3", {j, k}, 2'b01);
        check("b2b_done3", done, 1'b1);
        check("b2b_q3", q_model, 1'b1);
        @(negedge clk);
        check("b2b_jk4", {j, k}, 2'b00);
        check("b2b_q4", q_model, 1'b0);
        wait_idle(50);

        // Fill the FIFO behind a long HOLD.
        send(JK_HOLD, 15);
        for (int c = 0; c < 6; c++) begin
            send(2'($urandom_range(0, 3)), $urandom_range(0, 3));
            if (c == 3) check("full_ready_low", cmd_if.cmd_ready, 1'b0);
        end
        wait_idle(200);

        // Asynchronous reset in the third cycle of a TOGGLE count 7.
        send(JK_TOGGLE, 7);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_jk", {j, k}, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_q", q_model, 1'b0);
        check("arst_ready", cmd_if.cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_after_busy", busy, 1'b0);
        check("arst_after_jk", {j, k}, 2'b00);
        check("arst_after_q", q_model, 1'b0);

        // Random traffic, valid held until accepted.
        for (int c = 0; c < 600; c++) begin
            if (!cmd_if.cmd_valid || last_acc) begin
                if ($urandom_range(0, 2) != 0) begin
                    cmd_if.cmd_valid = 1'b1;
                    cmd_if.cmd_op    = jk_op_t'($urandom_range(0, 3));
                    cmd_if.cmd_count = ($urandom_range(0, 9) == 0) ? CNT_W'(15)
                                                                   : CNT_W'($urandom_range(0, 3));
                end else begin
                    cmd_if.cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        wait_idle(500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
